// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
// Row-strobe sequencer for a 4x3 matrix keypad. Each row is driven for a
// programmable settle time before the column bus is sampled. A single-key
// candidate is debounced and encoded to a 4-bit code, delivered once over a
// valid/ready handshake, and then debounced on release before the scan resumes.
// A key that arrives while the previous one is still unaccepted is dropped,
// and the sticky overflow flag records the drop.
module keypad_scan_ctrl #(
    parameter int unsigned SETTLE_CYCLES   = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] column,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overflow,
    input  logic       clr_overflow
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [CNT_W-1:0] SETTLE_RELOAD   = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEBOUNCE_RELOAD = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO        = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE         = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SCAN     = 3'd1,
        ST_DEBOUNCE = 3'd2,
        ST_REPORT   = 3'd3,
        ST_RELEASE  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // True when exactly one column line is active (a clean single press).
    function automatic logic is_onehot3(input logic [2:0] col);
        logic res;
        case (col)
            3'b001, 3'b010, 3'b100: res = 1'b1;
            default:                res = 1'b0;
        endcase
        return res;
    endfunction

    // One-hot strobe pattern for a row index; bit0 is the top row.
    function automatic logic [3:0] row_strobe(input logic [1:0] idx);
        logic [3:0] res;
        case (idx)
            2'd0:    res = 4'b0001;
            2'd1:    res = 4'b0010;
            2'd2:    res = 4'b0100;
            2'd3:    res = 4'b1000;
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

    // Key code for a (row index, one-hot column) pair.
    // Bottom row: '*' = 4'hA, '0' = 4'h0, '#' = 4'hB.
    function automatic logic [3:0] encode_key(input logic [1:0] idx,
                                              input logic [2:0] col);
        logic [3:0] res;
        case ({idx, col})
            5'b00_001: res = 4'h1;
            5'b00_010: res = 4'h2;
            5'b00_100: res = 4'h3;
            5'b01_001: res = 4'h4;
            5'b01_010: res = 4'h5;
            5'b01_100: res = 4'h6;
            5'b10_001: res = 4'h7;
            5'b10_010: res = 4'h8;
            5'b10_100: res = 4'h9;
            5'b11_001: res = 4'hA;
            5'b11_010: res = 4'h0;
            5'b11_100: res = 4'hB;
            default:   res = 4'h0;
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [1:0]       idx_q,   idx_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       cand_q,  cand_d;

    logic [3:0]       row_q,   row_d;
    logic [3:0]       code_q,  code_d;
    logic             valid_q, valid_d;
    logic             held_q,  held_d;
    logic             ovf_q,   ovf_d;

    logic             cnt_zero_s;
    logic             col_is_cand_s;
    logic             col_idle_s;
    logic             accept_s;
    logic             report_s;
    logic             load_s;

    assign cnt_zero_s    = (cnt_q == CNT_ZERO);
    assign col_is_cand_s = (column == cand_q);
    assign col_idle_s    = (column == 3'b000);

    // Sequencer register: state, row index, dwell counter, candidate column.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= CNT_ZERO;
            cand_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
        end
    end

    // Next-state logic: scan, debounce press, report, debounce release.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;

        if (!en) begin
            // Disabling parks the scanner; the handshake side is untouched.
            state_d = ST_IDLE;
            idx_d   = 2'd0;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SCAN;
                    idx_d   = 2'd0;
                    cnt_d   = SETTLE_RELOAD;
                end

                ST_SCAN: begin
                    if (cnt_zero_s) begin
                        if (is_onehot3(column)) begin
                            state_d = ST_DEBOUNCE;
                            cand_d  = column;
                            cnt_d   = DEBOUNCE_RELOAD;
                        end else begin
                            // No key, or a ghost/multi-key pattern: move on.
                            idx_d = idx_q + 2'd1;
                            cnt_d = SETTLE_RELOAD;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end

                ST_DEBOUNCE: begin
                    if (!col_is_cand_s) begin
                        // Bounce or change of key: abandon this row.
                        state_d = ST_SCAN;
                        idx_d   = idx_q + 2'd1;
                        cnt_d   = SETTLE_RELOAD;
                    end else if (cnt_zero_s) begin
                        state_d = ST_REPORT;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end

                ST_REPORT: begin
                    state_d = ST_RELEASE;
                    cnt_d   = DEBOUNCE_RELOAD;
                end

                ST_RELEASE: begin
                    if (!col_idle_s) begin
                        // Any activity restarts the release window.
                        cnt_d = DEBOUNCE_RELOAD;
                    end else if (cnt_zero_s) begin
                        state_d = ST_SCAN;
                        idx_d   = idx_q + 2'd1;
                        cnt_d   = SETTLE_RELOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    idx_d   = 2'd0;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // Row strobe and held flag follow the upcoming state so they are registered.
    always_comb begin
        row_d  = 4'b0000;
        held_d = 1'b0;
        if (state_d == ST_IDLE) begin
            row_d = 4'b0000;
        end else begin
            row_d = row_strobe(idx_d);
        end
        if ((state_d == ST_REPORT) || (state_d == ST_RELEASE)) begin
            held_d = 1'b1;
        end else begin
            held_d = 1'b0;
        end
    end

    // Handshake and overflow: load in REPORT when the slot is free or freeing.
    always_comb begin
        accept_s = valid_q & key_ready;
        report_s = (state_q == ST_REPORT) & en;
        load_s   = report_s & (~valid_q | accept_s);

        code_d  = code_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;

        if (load_s) begin
            code_d  = encode_key(idx_q, cand_q);
            valid_d = 1'b1;
        end else if (accept_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        // A drop sets the flag; setting takes priority over clearing.
        if (report_s && !load_s) begin
            ovf_d = 1'b1;
        end else if (clr_overflow) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q   <= 4'b0000;
            code_q  <= 4'h0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            row_q   <= row_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
            ovf_q   <= ovf_d;
        end
    end

    assign row       = row_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SETTLE=2, DEBOUNCE=3.
// A small keypad model returns press_col on the column bus while the strobed
// row matches press_row; bounce forces the column bus low.
module tb_keypad_scan_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] column;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_held;
    logic       overflow;
    logic       clr_overflow;

    logic [3:0] press_row;
    logic [2:0] press_col;
    logic       bounce;

    int total;
    int bad;

    keypad_scan_ctrl #(
        .SETTLE_CYCLES  (2),
        .DEBOUNCE_CYCLES(3),
        .CNT_W          (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .column      (column),
        .row         (row),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_held    (key_held),
        .overflow    (overflow),
        .clr_overflow(clr_overflow)
    );

    assign column = (((row & press_row) != 4'b0000) && !bounce) ? press_col : 3'b000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go_idle();
        en        = 1'b0;
        press_row = 4'b0000;
        press_col = 3'b000;
        bounce    = 1'b0;
        step(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        total++;
        if (row !== 4'b0000) begin bad++; $display("FAIL reset_row: got %b want 0000", row); end
        total++;
        if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", key_valid); end
        total++;
        if (key_code !== 4'h0) begin bad++; $display("FAIL reset_code: got %h want 0", key_code); end
        total++;
        if (key_held !== 1'b0 || overflow !== 1'b0) begin
            bad++; $display("FAIL reset_flags: held=%b ovf=%b want 0 0", key_held, overflow);
        end
        rst = 1'b0;
        step(1);
        total++;
        if (row !== 4'b0000) begin bad++; $display("FAIL idle_row: got %b want 0000", row); end
    endtask

    task automatic test_scan_no_key();
        logic [3:0] exp_row;
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            exp_row = 4'b0001;
            exp_row = exp_row << ((i / 2) % 4);
            total++;
            if (row !== exp_row || key_valid !== 1'b0) begin
                bad++;
                $display("FAIL scan_%0d: row=%b valid=%b want row=%b valid=0", i, row, key_valid, exp_row);
            end
        end
        go_idle();
    endtask

    task automatic test_press_5();
        key_ready = 1'b1;
        press_row = 4'b0010;
        press_col = 3'b010;
        en        = 1'b1;
        step(8);
        total++;
        if (key_held !== 1'b1 || key_valid !== 1'b0) begin
            bad++; $display("FAIL p5_report: held=%b valid=%b want 1 0", key_held, key_valid);
        end
        step(1);
        total++;
        if (key_valid !== 1'b1 || key_code !== 4'h5) begin
            bad++; $display("FAIL p5_valid: valid=%b code=%h want 1 5", key_valid, key_code);
        end
        step(1);
        total++;
        if (key_valid !== 1'b0 || key_held !== 1'b1) begin
            bad++; $display("FAIL p5_accept: valid=%b held=%b want 0 1", key_valid, key_held);
        end
        press_row = 4'b0000;
        step(2);
        total++;
        if (key_held !== 1'b1 || row !== 4'b0010) begin
            bad++; $display("FAIL p5_release_wait: held=%b row=%b want 1 0010", key_held, row);
        end
        step(1);
        total++;
        if (key_held !== 1'b0 || row !== 4'b0100) begin
            bad++; $display("FAIL p5_resume: held=%b row=%b want 0 0100", key_held, row);
        end
        go_idle();
    endtask

    task automatic test_bounce_star();
        key_ready = 1'b1;
        press_row = 4'b1000;
        press_col = 3'b001;
        en        = 1'b1;
        step(9);
        bounce = 1'b1;
        step(1);
        bounce = 1'b0;
        total++;
        if (row !== 4'b0001 || key_held !== 1'b0 || key_valid !== 1'b0) begin
            bad++; $display("FAIL bounce_abort: row=%b held=%b valid=%b want 0001 0 0", row, key_held, key_valid);
        end
        step(11);
        total++;
        if (key_held !== 1'b1 || key_valid !== 1'b0) begin
            bad++; $display("FAIL star_report: held=%b valid=%b want 1 0", key_held, key_valid);
        end
        step(1);
        total++;
        if (key_valid !== 1'b1 || key_code !== 4'hA) begin
            bad++; $display("FAIL star_code: valid=%b code=%h want 1 a", key_valid, key_code);
        end
        go_idle();
    endtask

    task automatic test_overflow();
        key_ready = 1'b0;
        press_row = 4'b0001;
        press_col = 3'b001;
        en        = 1'b1;
        step(7);
        total++;
        if (key_valid !== 1'b1 || key_code !== 4'h1 || overflow !== 1'b0) begin
            bad++; $display("FAIL ovf_first: valid=%b code=%h ovf=%b want 1 1 0", key_valid, key_code, overflow);
        end
        press_row = 4'b0000;
        step(3);
        press_row = 4'b0100;
        press_col = 3'b100;
        step(8);
        total++;
        if (overflow !== 1'b1 || key_code !== 4'h1 || key_valid !== 1'b1) begin
            bad++; $display("FAIL ovf_set: ovf=%b code=%h valid=%b want 1 1 1", overflow, key_code, key_valid);
        end
        clr_overflow = 1'b1;
        step(1);
        clr_overflow = 1'b0;
        total++;
        if (overflow !== 1'b0 || key_valid !== 1'b1 || key_code !== 4'h1) begin
            bad++; $display("FAIL ovf_clear: ovf=%b valid=%b code=%h want 0 1 1", overflow, key_valid, key_code);
        end
        key_ready = 1'b1;
        step(1);
        total++;
        if (key_valid !== 1'b0) begin bad++; $display("FAIL ovf_drain: valid=%b want 0", key_valid); end
        go_idle();
    endtask

    task automatic test_ghost();
        key_ready = 1'b1;
        press_row = 4'b0001;
        press_col = 3'b011;
        en        = 1'b1;
        step(3);
        total++;
        if (row !== 4'b0010 || key_held !== 1'b0) begin
            bad++; $display("FAIL ghost_skip: row=%b held=%b want 0010 0", row, key_held);
        end
        step(8);
        total++;
        if (key_valid !== 1'b0 || key_held !== 1'b0) begin
            bad++; $display("FAIL ghost_noreport: valid=%b held=%b want 0 0", key_valid, key_held);
        end
        go_idle();
    endtask

    task automatic test_en_drop_rst();
        key_ready = 1'b0;
        press_row = 4'b0001;
        press_col = 3'b010;
        en        = 1'b1;
        step(3);
        en = 1'b0;
        step(1);
        total++;
        if (row !== 4'b0000 || key_held !== 1'b0 || key_valid !== 1'b0) begin
            bad++; $display("FAIL endrop_idle: row=%b held=%b valid=%b want 0000 0 0", row, key_held, key_valid);
        end
        en = 1'b1;
        step(7);
        total++;
        if (key_valid !== 1'b1 || key_code !== 4'h2 || key_held !== 1'b1) begin
            bad++; $display("FAIL endrop_key2: valid=%b code=%h held=%b want 1 2 1", key_valid, key_code, key_held);
        end
        en = 1'b0;
        step(1);
        total++;
        if (key_valid !== 1'b1 || key_code !== 4'h2 || row !== 4'b0000 || key_held !== 1'b0) begin
            bad++; $display("FAIL endrop_keep: valid=%b code=%h row=%b held=%b want 1 2 0000 0",
                            key_valid, key_code, row, key_held);
        end
        en = 1'b1;
        step(7);
        total++;
        if (overflow !== 1'b1 || key_code !== 4'h2) begin
            bad++; $display("FAIL endrop_ovf: ovf=%b code=%h want 1 2", overflow, key_code);
        end
        rst = 1'b1;
        step(1);
        total++;
        if (key_valid !== 1'b0 || overflow !== 1'b0 || row !== 4'b0000 ||
            key_held !== 1'b0 || key_code !== 4'h0) begin
            bad++; $display("FAIL midrst: valid=%b ovf=%b row=%b held=%b code=%h want 0 0 0000 0 0",
                            key_valid, overflow, row, key_held, key_code);
        end
        rst = 1'b0;
        go_idle();
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        en           = 1'b0;
        key_ready    = 1'b0;
        clr_overflow = 1'b0;
        press_row    = 4'b0000;
        press_col    = 3'b000;
        bounce       = 1'b0;

        test_reset();
        test_scan_no_key();
        test_press_5();
        test_bounce_star();
        test_overflow();
        test_ghost();
        test_en_drop_rst();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Sequencer for the 4x3 matrix keypad.
- Drives one-hot row strobes with a programmable settle time, then samples the 3-bit column bus.
- Debounces press and release, and encodes the key to a 4-bit code.
- Delivers each key once over a valid/ready handshake to the display/decoder logic. An overflow flag is sticky.

Parameters:
- SETTLE_CYCLES, 4: clocks a row is driven before column is sampled (>=1).
- DEBOUNCE_CYCLES, 1000: consecutive stable clocks required to accept a press or a release (>=1).
- CNT_W, 16: width of the shared dwell counter. Both cycle parameters must be < 2^CNT_W.

Ports:
- clk, input, 1: single clock; every register updates on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: scan enable.
- column, input, 3: keypad column sense, active-high. bit0 = left, bit2 = right.
- row, output, 4: one-hot row strobe, active-high. bit0 = top row.
- key_code, output, 4: encoded key.
- key_valid, output, 1: key_code is valid.
- key_ready, input, 1: consumer accepts key_code.
- key_held, output, 1: a debounced key is currently pressed.
- overflow, output, 1: sticky; set when a key was dropped.
- clr_overflow, input, 1: clears overflow.

Behaviour:
- Reset values: state = IDLE, row = 4'b0000, row index = 0, counter = 0, key_code = 4'h0, key_valid = 0, key_held = 0, overflow = 0.
- Key map, row0..row3 x col bit0/1/2:
  - row0: 1, 2, 3
  - row1: 4, 5, 6
  - row2: 7, 8, 9
  - row3: * = 4'hA, 0 = 4'h0, # = 4'hB
- IDLE: row = 0. When en = 1, go to SCAN with row index 0 and counter = SETTLE_CYCLES-1.
- SCAN: row = one-hot(index). Counter decrements each clock. When counter = 0, column is sampled:
  - Exactly one bit set: latch cand_col, go to DEBOUNCE with counter = DEBOUNCE_CYCLES-1.
  - Zero bits or more than one bit set (ghost/multi-key): advance index (3 wraps to 0), reload SETTLE_CYCLES-1, stay in SCAN.
- DEBOUNCE: row is held.
  - If column != cand_col on any clock, abort: advance index and return to SCAN.
  - If counter = 0 and column == cand_col, go to REPORT.
- REPORT: lasts exactly one clock, then RELEASE; key_held = 1 from this state onward.
  - If key_valid = 0, or key_valid & key_ready are both high this cycle: load key_code and set key_valid = 1 next clock.
  - Otherwise: keep the old key and set overflow = 1.
- RELEASE: row is held, key_held = 1.
  - Counter reloads to DEBOUNCE_CYCLES-1 whenever column != 0.
  - Counter decrements while column == 0.
  - When counter = 0 and column == 0: key_held = 0, advance index, go to SCAN.
- Handshake:
  - key_valid and key_code stay stable until a cycle with key_valid & key_ready.
  - After acceptance, key_valid drops the next clock unless REPORT loads a new key in that same cycle; then valid stays 1 with the new code.
  - key_ready while key_valid = 0 is ignored.
- Overflow:
  - Set only in REPORT.
  - clr_overflow clears it; set wins over clear in the same cycle.
- en = 0: from any state, go to IDLE next clock with row = 0, key_held = 0 and index reset to 0. A pending key_valid/key_code is preserved.
- rst mid-operation: all state returns to reset values next clock, including dropping key_valid.
- Latency: first row strobe appears 1 clock after en rises. A press is reported at most 4*SETTLE_CYCLES + DEBOUNCE_CYCLES + 2 clocks after it becomes stable.

Test Plan:
- SETTLE=2, DEBOUNCE=3, en=1, no key -> row cycles 0001, 0010, 0100, 1000, 0001, each held 2 clocks; key_valid stays 0.
- Press row1/col 3'b010 held stable, key_ready=1 -> key_code = 4'h5, key_valid pulses 1 clock, key_held = 1 until column stays 0 for 3 clocks, then scan resumes at row2.
- Press on row3/col 3'b001 with 1-clock bounce in DEBOUNCE -> abort, no report; on a later stable pass key_code = 4'hA.
- key_ready=0, press '1', release, then press '9' -> key_code stays 4'h1 and overflow = 1. Pulse clr_overflow -> overflow = 0. key_ready=1 -> valid drops.
- column = 3'b011 on row0 -> ignored, no report, scan advances to row1.
- Drop en during DEBOUNCE -> row = 0 next clock, IDLE. Assert rst with key_valid=1 -> key_valid = 0, overflow = 0, row = 0 next clock.
